// File: rtl/dense_mac_engine_if.sv
// Purpose: bundles the engine's control, memory-read and result signals.
// Latency: none, wiring only; read data returns one cycle after its address.
// Backpressure: none; memory returns at fixed latency and results hold until the next start.
// Ports: start/busy/done control, addr1/addr2 paired read addresses, w_flat/x1/x2 read data,
//        scores/class_idx/max_score results.
interface dense_mac_engine_if #(
  parameter int NC     = 9,
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 26
);
  logic                        start;
  logic [ADDR_W-1:0]           addr1;
  logic [ADDR_W-1:0]           addr2;
  logic [(NC+1)*16-1:0]        w_flat;
  logic signed [7:0]           x1;
  logic signed [7:0]           x2;
  logic                        busy;
  logic                        done;
  logic [(NC+1)*ACC_W-1:0]     scores;
  logic [3:0]                  class_idx;
  logic signed [ACC_W-1:0]     max_score;

  // engine side: issues addresses, consumes read data, produces results
  modport master (
    input  start, w_flat, x1, x2,
    output addr1, addr2, busy, done, scores, class_idx, max_score
  );

  // environment side: controller plus weight memory and feature buffer
  modport slave (
    output start, w_flat, x1, x2,
    input  addr1, addr2, busy, done, scores, class_idx, max_score
  );
endinterface

// File: rtl/dense_mac_engine.sv
// Purpose: fully-connected output layer, two MACs per class per cycle, then a sequential argmax.
// Latency: done pulses N_IN/2+NC+3 cycles after start is accepted.
// Backpressure: none; start is ignored while busy, memories must answer one cycle after the address.
// Ports: clk, rst (sync, active-low), bus (dense_mac_engine_if.master).
module dense_mac_engine #(
  parameter int N_IN   = 784,
  parameter int NC     = 9,
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  dense_mac_engine_if.master    bus
);

  localparam int KW = ADDR_W - 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_IN / 2 - 1);
  localparam logic [3:0]    C_LAST = 4'(NC);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, ARGMAX, DONE} state_t;

  state_t                  state;
  logic [KW-1:0]           k;
  logic                    vld;
  logic signed [ACC_W-1:0] acc [NC+1];
  logic signed [16:0]      pair [NC+1];
  logic [3:0]              ai;
  logic [3:0]              cand_idx;
  logic signed [ACC_W-1:0] cand_val;
  logic [3:0]              nxt_idx;
  logic signed [ACC_W-1:0] nxt_val;
  logic signed [ACC_W-1:0] sel_val;
  logic                    busy_q;
  logic                    done_q;
  logic [3:0]              class_q;
  logic signed [ACC_W-1:0] max_q;

  // the pair index is the address with its low bit dropped, so addr2 is always addr1+1
  assign bus.addr1     = {k, 1'b0};
  assign bus.addr2     = {k, 1'b1};
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.class_idx = class_q;
  assign bus.max_score = max_q;

  for (genvar g = 0; g <= NC; g++) begin : g_pack
    assign bus.scores[g*ACC_W +: ACC_W] = acc[g];
  end

  // two full-precision 16-bit products summed into 17 bits
  function automatic logic signed [16:0] mac2(input logic signed [7:0] xa, input logic signed [7:0] wa,
                                              input logic signed [7:0] xb, input logic signed [7:0] wb);
    logic signed [15:0] pa;
    logic signed [15:0] pb;
    pa = xa * wa;
    pb = xb * wb;
    return {pa[15], pa} + {pb[15], pb};
  endfunction

  // one extra guard bit; overflow shows as the top two bits disagreeing
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [16:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-16){b[16]}}, b};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  always_comb begin
    for (int c = 0; c <= NC; c++) begin
      pair[c] = mac2(bus.x1, $signed(bus.w_flat[(2*c)*8 +: 8]),
                     bus.x2, $signed(bus.w_flat[(2*c+1)*8 +: 8]));
    end
  end

  // argmax step: slot 0 seeds the candidate, later slots win only when strictly greater
  always_comb begin
    sel_val = '0;
    for (int c = 0; c <= NC; c++) begin
      if (ai == 4'(c)) sel_val = acc[c];
    end
    nxt_idx = cand_idx;
    nxt_val = cand_val;
    if (ai == 4'd0) begin
      nxt_idx = 4'd0;
      nxt_val = sel_val;
    end else if (sel_val > cand_val) begin
      nxt_idx = ai;
      nxt_val = sel_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      k        <= '0;
      vld      <= 1'b0;
      ai       <= '0;
      cand_idx <= '0;
      cand_val <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      class_q  <= '0;
      max_q    <= '0;
      for (int c = 0; c <= NC; c++) acc[c] <= '0;
    end else begin
      // data addressed in a RUN cycle comes back one cycle later
      vld    <= (state == RUN);
      done_q <= 1'b0;
      if (vld) begin
        for (int c = 0; c <= NC; c++) acc[c] <= sat_add(acc[c], pair[c]);
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            k      <= '0;
            busy_q <= 1'b1;
            for (int c = 0; c <= NC; c++) acc[c] <= '0;
          end
        end
        RUN: begin
          // k stays on the last pair so the addresses hold through DRAIN
          if (k == K_LAST) state <= DRAIN;
          else             k     <= k + 1'b1;
        end
        DRAIN: begin
          state <= ARGMAX;
          ai    <= '0;
        end
        ARGMAX: begin
          cand_idx <= nxt_idx;
          cand_val <= nxt_val;
          if (ai == C_LAST) begin
            state   <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            class_q <= nxt_idx;
            max_q   <= nxt_val;
          end else begin
            ai <= ai + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dense_mac_engine.md
# dense_mac_engine

Fully-connected output-layer engine for the MNIST classifier. It sits directly downstream of the 10-column dual-port weight memory. It sequences paired read addresses into that memory and into the feature (pixel) buffer, multiply-accumulates two input/weight pairs per cycle for each of the NC+1 class columns, then runs a sequential argmax and reports the winning class.

## Interface
- `N_IN`, 784, number of input features; must be even, at least 2.
- `NC`, 9, index of last class; NC+1 columns, matches the weight memory.
- `ADDR_W`, 10, width of `addr1`/`addr2`.
- `ACC_W`, 26, signed accumulator width per class.

Ports:
- `clk`  in  1  the only clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  begins one inference; sampled only in IDLE.
- `addr1`  out  ADDR_W  even feature/weight address, shared by weight memory and feature buffer.
- `addr2`  out  ADDR_W  odd address, always `addr1`+1.
- `w_flat`  in  (NC+1)*16  signed 8-bit weights. Column c port p sits at bits [(2c+p)*8 +: 8]. Returned one cycle after the address.
- `x1`, `x2`  in  8 each  signed features at `addr1`/`addr2`, with the same one-cycle latency.
- `busy`  out  1  high from start acceptance until `done`.
- `done`  out  1  one-cycle pulse when results are valid.
- `scores`  out  (NC+1)*ACC_W  accumulators; class c at [c*ACC_W +: ACC_W].
- `class_idx`  out  4  argmax result.
- `max_score`  out  ACC_W  score of `class_idx`.

## Operation
The engine is a state machine with states IDLE, RUN, DRAIN, ARGMAX and DONE.

- **IDLE:** `start`=1 moves to RUN. In the same edge, all accumulators are cleared, the pair counter k is set to 0 and `busy` is set.
- **RUN:** drives `addr1`=2k and `addr2`=2k+1, and k increments every cycle.
  - A one-bit valid pipe, delayed one cycle, marks the returning data.
  - When k reaches N_IN/2-1, the state moves to DRAIN.
- **Accumulate:** on every cycle with valid data, for each c: `acc[c]` += `x1`*`w[c][0]` + `x2`*`w[c][1]`.
  - Each product is a full 16-bit signed value; the pair sum is 17-bit.
  - The add saturates to the signed ACC_W range, never wrapping.
- **DRAIN:** one cycle that absorbs the last returning pair, then moves to ARGMAX. `addr1`/`addr2` hold their last values.
- **ARGMAX:** takes NC+1 cycles, scanning c=0..NC.
  - Candidate starts at class 0.
  - Class c replaces the candidate only if strictly greater, so ties keep the lower index.
  - The last compare moves to DONE.
- **DONE:** `done`=1 and `busy`=0, registered `class_idx` and `max_score` are updated, then the state returns to IDLE.
- **Result hold:** `scores`, `class_idx` and `max_score` hold until the next accepted `start`; `scores` clear at that point.
- **`start` outside IDLE** (including in DONE) is ignored.
- **`rst`=0 at any edge, including mid-RUN:** state IDLE, accumulators 0, k=0, valid pipe cleared. No `done` is produced for the aborted run.

## Timing
Reset values: `addr1`=0, `addr2`=1, `busy`=0, `done`=0, `scores`=0, `class_idx`=0, `max_score`=0.

Cycle numbering, with `start` sampled at the edge ending cycle 0:
- Cycles 1..N_IN/2 are RUN; pair k is addressed in cycle k+1.
- Pair data arrives in cycle k+2 and is accumulated at the end of that cycle.
- Cycle N_IN/2+1 is DRAIN.
- Cycles N_IN/2+2..N_IN/2+NC+2 are ARGMAX.
- `done` is high in cycle N_IN/2+NC+3, which is cycle 404 for the defaults.

Other timing rules:
- The engine is not back-pressured; upstream memories must return data at a fixed one-cycle latency.
- Minimum gap between `done` and the next accepted `start` is zero: `start` in the cycle after `done` is accepted.

## Test plan
- **Reset:** assert `rst`=0 for 2 cycles, then release -> all outputs at reset values, `busy`=0, no `done` for 20 idle cycles.
- **Basic run:** all x=1, weight column c = c at every address, defaults -> `done` at cycle 404, `scores[c]`=784·c, `class_idx`=9, `max_score`=7056.
- **Signed math and ties:** x1=-2, x2=3, column 3 weights (5,5), column 7 weights (5,5), all other columns 0, N_IN=4 -> `scores[3]`=`scores[7]`=10, `class_idx`=3, `done` at cycle 14.
- **Saturation:** ACC_W=20, all x=127, all w=127 -> every score=524287, `class_idx`=0. Repeat with w=-128 -> every score=-524288.
- **Abort:** pull `rst` low at cycle 200 of a run, then issue a new `start` -> the new run's scores equal those of a clean run, and exactly one `done` is seen.
- **Start handling:** hold `start`=1 throughout -> back-to-back runs, `done` every 405 cycles, no start accepted while `busy`; verify `scores` clear on each restart.
